mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the multicycle datapath and the word-wide data `ram` (async read, write on clock edge). It converts byte-addressed byte/halfword/word loads and stores into word accesses. Sub-word stores use read-modify-write. Loads are sign- or zero-extended. Misaligned accesses are flagged and suppressed. All datapath memory traffic passes through this block; the `ram` sees only word addresses.

## Interface
- `ADDR_WIDTH`, 10, word-address width of the attached `ram` (depth 2^ADDR_WIDTH words); data width fixed at 32.

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  1  access request, sampled only when `busy`=0
- `we`  in  1  1=store, 0=load
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `sign_ext`  in  1  loads only: 1 sign-extend, 0 zero-extend
- `addr`  in  32  byte address
- `wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- `rdata`  out  32  registered load result, held until next successful load completes
- `done`  out  1  one-cycle pulse: access finished (or rejected)
- `misaligned`  out  1  one-cycle pulse coincident with `done` for rejected access
- `busy`  out  1  state != IDLE
- `ram_write`  out  1  to `ram` write
- `ram_addr`  out  ADDR_WIDTH  to `ram` addr = latched `addr[ADDR_WIDTH+1:2]`
- `ram_inData`  out  32  to `ram` inData (merged store word)
- `ram_outData`  in  32  from `ram` outData (combinational read of `ram_addr`)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE & `req`: latch `we`, `size`, `sign_ext`, `addr`, `wdata`; next state chosen by access type.
  - Misaligned → DONE with `misaligned` set. Misaligned means: `size`=01 & `addr[0]`; `size`=10 & `addr[1:0]`≠0; or `size`=11.
  - Load → READ.
  - Word store → WRITE.
  - Byte/half store → READ.
- READ:
  - For a load, register the selected, extended lane into `rdata`, then go to DONE.
  - For a store, register `ram_outData` into a merge register, then go to WRITE.
- WRITE: `ram_write`=1. `ram_inData` is either the merge word with the target lane replaced by `wdata` low bits, or `wdata` for a word store. Next state DONE.
- DONE: `done`=1, `misaligned` as latched; next state IDLE.
- Lanes are little-endian:
  - byte offset k occupies bits [8k+7:8k];
  - a halfword at offset 0 occupies [15:0], at offset 2 occupies [31:16].
- Address bits above `ADDR_WIDTH+1` are ignored; addresses wrap modulo RAM size.
- A misaligned access performs no RAM write and leaves `rdata` unchanged.
- `req` while `busy`=1 is ignored (not queued).
- `ram_write` = (state==WRITE) & !`reset`, so no RAM write occurs on an edge where `reset` is high.

## Timing
- Reset values:
  - state IDLE;
  - `rdata`=0, `done`=0, `misaligned`=0, `busy`=0, `ram_write`=0;
  - `ram_addr`=0, `ram_inData`=0;
  - all latches 0.
- Cycle 0 is the cycle in which `req`=1 & `busy`=0; acceptance happens on the edge ending cycle 0.
- Load: READ in cycle 1. `rdata` is valid and `done`=1 in cycle 2; IDLE in cycle 3.
- Word store: WRITE in cycle 1 (RAM updated at end of cycle 1); `done` in cycle 2.
- Sub-word store: READ in cycle 1, WRITE in cycle 2, `done` in cycle 3.
- Misaligned: `done`=`misaligned`=1 in cycle 1.
- Earliest next accept is the cycle after `done` (the IDLE cycle).
- `reset` in any state: next cycle IDLE and outputs at reset values. An in-flight store is aborted; if `reset` coincides with WRITE, RAM is unmodified.
- `ram_addr` and `ram_inData` come from registers/latches; the only combinational path is `ram_outData` → lane select/merge → registers.

## Test plan
- Word store/load:
  - Store `addr`=0x48, `wdata`=0xDEADBEEF → `ram_write` in cycle 1 at `ram_addr`=0x12, `done` in cycle 2.
  - Load word 0x48 → `rdata`=0xDEADBEEF in cycle 2.
- Byte store RMW: word 0x12 holds 0xDEADBEEF; store byte `addr`=0x49, `wdata`=0x55 → READ, then WRITE with `ram_inData`=0xDEAD55EF, `done` in cycle 3.
- Extension: word holds 0x80F0_7F01.
  - Load byte offset 2, `sign_ext`=1 → 0xFFFFFFF0; `sign_ext`=0 → 0x000000F0.
  - Load half offset 2 signed → 0xFFFF80F0.
- Misaligned: word load at `addr`=0x4A, then half store at 0x49 → each gives `done`=`misaligned`=1 in cycle 1, no `ram_write`, `rdata` unchanged.
- Reset during WRITE of a byte store → no RAM change; next cycle `busy`=0, `done`=0, `rdata`=0.
- Busy ignore/wrap:
  - A second `req` during READ is dropped.
  - `addr`=0x1000_0004 with `ADDR_WIDTH`=10 → `ram_addr`=0x001.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns byte-addressed byte/half/word accesses into word
// accesses on a RAM with async read, using read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  misaligned,
  output logic                  busy,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_inData,
  input  logic [31:0]           ram_outData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        we_r;
  logic        sign_r;
  logic        mis_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;

  logic        mis_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_s;
  logic [31:0] merge_s;
  logic        unused_addr_s;

  // Address bits above the RAM word range wrap away.
  assign unused_addr_s = ^addr[31:ADDR_WIDTH+2];

  // Gated by reset so an aborted store never reaches the RAM.
  assign ram_write = (state_r == WRITE) && !reset;
  assign busy      = (state_r != IDLE);

  // Alignment check on the incoming request.
  always_comb begin
    case (size)
      2'b00:   mis_s = 1'b0;
      2'b01:   mis_s = addr[0];
      2'b10:   mis_s = (addr[1:0] != 2'b00);
      default: mis_s = 1'b1;
    endcase
  end

  // Lane select and extension of the RAM word for loads.
  always_comb begin
    byte_s = ram_outData[{off_r, 3'b000} +: 8];
    if (off_r[1]) begin
      half_s = ram_outData[31:16];
    end else begin
      half_s = ram_outData[15:0];
    end
    case (size_r)
      2'b00:   load_s = {{24{sign_r & byte_s[7]}}, byte_s};
      2'b01:   load_s = {{16{sign_r & half_s[15]}}, half_s};
      default: load_s = ram_outData;
    endcase
  end

  // Read-modify-write merge: replace the target lane of the fetched word.
  always_comb begin
    merge_s = ram_outData;
    case (size_r)
      2'b00: merge_s[{off_r, 3'b000} +: 8] = wdata_r[7:0];
      2'b01: begin
        if (off_r[1]) begin
          merge_s[31:16] = wdata_r[15:0];
        end else begin
          merge_s[15:0] = wdata_r[15:0];
        end
      end
      default: merge_s = wdata_r;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      sign_r     <= 1'b0;
      mis_r      <= 1'b0;
      size_r     <= 2'b00;
      off_r      <= 2'b00;
      wdata_r    <= 32'h0000_0000;
      rdata      <= 32'h0000_0000;
      done       <= 1'b0;
      misaligned <= 1'b0;
      ram_addr   <= '0;
      ram_inData <= 32'h0000_0000;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            we_r     <= we;
            size_r   <= size;
            sign_r   <= sign_ext;
            off_r    <= addr[1:0];
            wdata_r  <= wdata;
            mis_r    <= mis_s;
            ram_addr <= addr[ADDR_WIDTH+1:2];
            if (mis_s) begin
              state_r    <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (!we || (size != 2'b10)) begin
              state_r <= READ;
            end else begin
              state_r    <= WRITE;
              ram_inData <= wdata;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (!we_r) begin
            rdata   <= load_s;
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            ram_inData <= merge_s;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          state_r    <= DONE;
          done       <= 1'b1;
          misaligned <= mis_r;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
